cpu_mem_bridge: RTL and testbench

CPU_MEM_BRIDGE -- requirements
Module: cpu_mem_bridge

---
 rtl/cpu_mem_bridge.sv | 166 ++++++++++++++++
 tb/tb_cpu_mem_bridge.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: single-outstanding CPU-to-memory bridge.
// Latches a CPU request, checks alignment, drives a word-addressed memory
// access with byte-lane masks, and returns a one-cycle response with an
// error flag for misaligned/illegal/conflicting requests and timeouts.
module cpu_mem_bridge #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_size,
  output logic        cpu_resp,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_wmask,
  input  logic        pmem_resp,
  input  logic [31:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        write_q;
  logic [15:0] count;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_any;
  logic        req_both;
  logic        req_ok;
  logic        timed_out;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SIZE_BYTE: is_aligned = 1'b1;
      SIZE_HALF: is_aligned = (lsb[0] == 1'b0);
      SIZE_WORD: is_aligned = (lsb == 2'b00);
      default:   is_aligned = 1'b0;
    endcase
  endfunction

  assign req_any   = cpu_read | cpu_write;
  assign req_both  = cpu_read & cpu_write;
  assign req_ok    = req_any && !req_both && is_aligned(cpu_size, cpu_address[1:0]);
  assign timed_out = (count == LAST_COUNT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a response in the final counted cycle beats the timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_any) state_next = req_ok ? ACCESS : DONE;
      end
      ACCESS: begin
        if (pmem_resp || timed_out) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latches, timeout counter and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      count   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            addr_q  <= cpu_address;
            wdata_q <= cpu_wdata;
            size_q  <= cpu_size;
            write_q <= cpu_write;
            count   <= '0;
            rdata_q <= '0;
            err_q   <= !req_ok;
          end
        end
        ACCESS: begin
          if (pmem_resp) begin
            rdata_q <= write_q ? '0 : pmem_rdata;
            err_q   <= 1'b0;
          end else begin
            count <= count + 16'd1;
            if (timed_out) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded only from registered state and latches, so no input reaches an output combinationally.
  always_comb begin
    cpu_resp     = 1'b0;
    cpu_rdata    = '0;
    cpu_err      = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    pmem_wmask   = '0;
    case (state)
      ACCESS: begin
        pmem_read    = !write_q;
        pmem_write   = write_q;
        pmem_address = {addr_q[31:2], 2'b00};
        case (size_q)
          SIZE_BYTE: pmem_wdata = {4{wdata_q[7:0]}};
          SIZE_HALF: pmem_wdata = {2{wdata_q[15:0]}};
          default:   pmem_wdata = wdata_q;
        endcase
        if (write_q) begin
          case (size_q)
            SIZE_BYTE: pmem_wmask = 4'b0001 << addr_q[1:0];
            SIZE_HALF: pmem_wmask = addr_q[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: pmem_wmask = 4'b1111;
            default:   pmem_wmask = 4'b0000;
          endcase
        end
      end
      DONE: begin
        cpu_resp  = 1'b1;
        cpu_rdata = rdata_q;
        cpu_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Testbench for cpu_mem_bridge: directed requests push expected memory
// accesses and CPU responses into queues; independent monitors pop and compare.
module tb_cpu_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_address = '0;
  logic [31:0] cpu_wdata = '0;
  logic [1:0]  cpu_size = '0;
  logic        cpu_resp;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_wmask;
  logic        pmem_resp;
  logic [31:0] pmem_rdata;

  logic        resp_r = 1'b0;
  logic        stray = 1'b0;
  logic [31:0] mem_rdata = '0;
  int          resp_delay = 0;
  int          cyc = 0;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        wr;
    int          len;
  } pexp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rexp_t;

  pexp_t pq[$];
  rexp_t rq[$];

  assign pmem_resp  = resp_r | stray;
  assign pmem_rdata = mem_rdata;

  cpu_mem_bridge #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_read     (cpu_read),
    .cpu_write    (cpu_write),
    .cpu_address  (cpu_address),
    .cpu_wdata    (cpu_wdata),
    .cpu_size     (cpu_size),
    .cpu_resp     (cpu_resp),
    .cpu_rdata    (cpu_rdata),
    .cpu_err      (cpu_err),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_wmask   (pmem_wmask),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory-side monitor and responder.
  pexp_t cur;
  int    scnt = 0;
  always @(negedge clk) begin
    if (pmem_read || pmem_write) begin
      if (scnt == 0) begin
        if (pq.size() == 0) begin
          chk("unexpected_access", 32'd1, 32'd0);
          cur = '{addr: pmem_address, wdata: pmem_wdata, mask: pmem_wmask, wr: pmem_write, len: 0};
        end else begin
          cur = pq.pop_front();
          chk("pmem_address", pmem_address, cur.addr);
          chk("pmem_wmask", {28'd0, pmem_wmask}, {28'd0, cur.mask});
          chk("pmem_dir", {30'd0, pmem_read, pmem_write}, {30'd0, !cur.wr, cur.wr});
          if (cur.wr) chk("pmem_wdata", pmem_wdata, cur.wdata);
        end
      end else begin
        chk("stable_addr", pmem_address, cur.addr);
        chk("stable_mask", {28'd0, pmem_wmask}, {28'd0, cur.mask});
        if (cur.wr) chk("stable_wdata", pmem_wdata, cur.wdata);
      end
      scnt++;
      resp_r = (scnt == resp_delay);
    end else begin
      if (scnt != 0) chk("strobe_len", scnt, cur.len);
      scnt = 0;
      resp_r = 1'b0;
    end
  end

  // CPU-side response monitor.
  rexp_t re;
  logic  prev_resp = 1'b0;
  always @(negedge clk) begin
    if (cpu_resp) begin
      if (prev_resp) chk("resp_pulse_width", 32'd2, 32'd1);
      if (rq.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        re = rq.pop_front();
        chk("cpu_rdata", cpu_rdata, re.rdata);
        chk("cpu_err", {31'd0, cpu_err}, {31'd0, re.err});
        chk("resp_cycle", cyc, re.cyc);
      end
    end else begin
      chk("quiet_outputs", {cpu_rdata[30:0], cpu_err}, 32'd0);
    end
    prev_resp = cpu_resp;
  end

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input int dly, input logic [31:0] mrd,
                        input bit acc, input logic [31:0] ea, input logic [31:0] ewd,
                        input logic [3:0] em, input int elen,
                        input logic [31:0] erd, input logic eerr, input int elat);
    bit seen = 0;
    @(negedge clk);
    resp_delay = dly;
    mem_rdata  = mrd;
    if (acc) pq.push_back('{addr: ea, wdata: ewd, mask: em, wr: wr, len: elen});
    rq.push_back('{rdata: erd, err: eerr, cyc: cyc + elat});
    cpu_read = rd; cpu_write = wr; cpu_address = a; cpu_wdata = wd; cpu_size = sz;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_resp) begin seen = 1; break; end
    end
    if (!seen) chk("resp_wait_timeout", 32'd0, 32'd1);
    cpu_read = 1'b0; cpu_write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    @(negedge clk);
    chk("reset_strobes", {30'd0, pmem_read, pmem_write}, 32'd0);
    chk("reset_address", pmem_address, 32'd0);
    chk("reset_wmask", {28'd0, pmem_wmask}, 32'd0);
    chk("reset_resp", {31'd0, cpu_resp}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //     rd wr addr          wdata         sz    dly rdata         acc paddr         pwdata        mask  len erd           err lat
    do_req(1, 0, 32'h00001004, 32'h0,        2'b10, 3, 32'hDEADBEEF, 1, 32'h00001004, 32'h0,        4'h0, 3, 32'hDEADBEEF, 0, 4);
    do_req(0, 1, 32'h00002003, 32'h000000A5, 2'b00, 2, 32'h11223344, 1, 32'h00002000, 32'hA5A5A5A5, 4'h8, 2, 32'h0,        0, 3);
    do_req(1, 0, 32'h00000101, 32'h0,        2'b01, 1, 32'h0,        0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        1, 1);
    do_req(1, 0, 32'h00003000, 32'h0,        2'b10, 0, 32'h55555555, 1, 32'h00003000, 32'h0,        4'h0, 4, 32'h0,        1, 5);
    do_req(1, 0, 32'h00003004, 32'h0,        2'b10, 4, 32'hCAFEF00D, 1, 32'h00003004, 32'h0,        4'h0, 4, 32'hCAFEF00D, 0, 5);
    do_req(0, 1, 32'h00004002, 32'h1234BEEF, 2'b01, 1, 32'h0,        1, 32'h00004000, 32'hBEEFBEEF, 4'hC, 1, 32'h0,        0, 2);
    do_req(0, 1, 32'h00004000, 32'h00005A5A, 2'b01, 1, 32'h0,        1, 32'h00004000, 32'h5A5A5A5A, 4'h3, 1, 32'h0,        0, 2);
    do_req(0, 1, 32'h00005008, 32'h89ABCDEF, 2'b10, 1, 32'h0,        1, 32'h00005008, 32'h89ABCDEF, 4'hF, 1, 32'h0,        0, 2);
    do_req(1, 0, 32'h00006001, 32'h0,        2'b00, 1, 32'h0BADF00D, 1, 32'h00006000, 32'h0,        4'h0, 1, 32'h0BADF00D, 0, 2);
    do_req(0, 1, 32'h00002001, 32'h000000C3, 2'b00, 1, 32'h0,        1, 32'h00002000, 32'hC3C3C3C3, 4'h2, 1, 32'h0,        0, 2);
    do_req(0, 1, 32'h00007000, 32'h0,        2'b11, 1, 32'h0,        0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        1, 1);
    do_req(1, 0, 32'h00007002, 32'h0,        2'b10, 1, 32'h0,        0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        1, 1);
    do_req(1, 1, 32'h00008000, 32'h0,        2'b10, 1, 32'h0,        0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        1, 1);

    // Stray memory response while idle.
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_no_strobe", {30'd0, pmem_read, pmem_write}, 32'd0);
      chk("stray_no_resp", {31'd0, cpu_resp}, 32'd0);
      @(negedge clk);
    end

    // Reset during the second ACCESS cycle.
    resp_delay = 0;
    pq.push_back('{addr: 32'h00009000, wdata: 32'h0, mask: 4'h0, wr: 1'b0, len: 2});
    cpu_read = 1'b1; cpu_address = 32'h00009000; cpu_size = 2'b10;
    @(negedge clk);
    chk("pre_reset_strobe", {31'd0, pmem_read}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_strobes", {30'd0, pmem_read, pmem_write}, 32'd0);
    chk("post_reset_resp", {31'd0, cpu_resp}, 32'd0);
    rst = 1'b0;
    cpu_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_resp_after_reset", {31'd0, cpu_resp}, 32'd0);
    end
    do_req(1, 0, 32'h0000A008, 32'h0,        2'b10, 2, 32'h600DCAFE, 1, 32'h0000A008, 32'h0,        4'h0, 2, 32'h600DCAFE, 0, 3);

    repeat (5) @(negedge clk);
    chk("pmem_queue_drained", pq.size(), 32'd0);
    chk("resp_queue_drained", rq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
